pipe_wb_reg: RTL and testbench
==============================

PIPE_WB_REG -- requirements
Module: pipe_wb_reg

Interface
REQ-001 The block SHALL have parameter LANES, default 1, giving the number of independent write-back lanes.
REQ-002 The block SHALL have parameter ADDR_W, default 5, giving the register-address width per lane.
REQ-003 The block SHALL have parameter DATA_W, default 32, giving the write-data width per lane.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on posedge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset (asserted at 0).
REQ-006 The block SHALL have port flush, input, 1 bit: synchronous pipeline flush.
REQ-007 The block SHALL have ports in_valid (input, 1) and in_ready (output, 1): upstream handshake.
REQ-008 The block SHALL have port in_wd, input, LANES*ADDR_W: destination register per lane.
REQ-009 The block SHALL have port in_wreg, input, LANES: write enable per lane.
REQ-010 The block SHALL have port in_wdata, input, LANES*DATA_W: write data per lane.
REQ-011 The block SHALL have ports out_valid (output, 1) and out_ready (input, 1): downstream handshake.
REQ-012 The block SHALL have ports wb_wd (output, LANES*ADDR_W), wb_wreg (output, LANES) and wb_wdata (output, LANES*DATA_W): registered payload to the register file.

Function
REQ-013 A beat SHALL be accepted when in_valid && in_ready and delivered when out_valid && out_ready; beats leave in acceptance order, none duplicated or dropped except by flush.
REQ-014 The occupancy FSM SHALL have states EMPTY, ONE and TWO; push only: EMPTY->ONE, ONE->TWO; pop only: TWO->ONE, ONE->EMPTY; push and pop together: state unchanged.
REQ-015 out_valid SHALL be 1 exactly when the state is not EMPTY; in_ready SHALL be a flop output equal to 1 exactly when the state is not TWO.
REQ-016 Latency SHALL be one cycle: a beat accepted at edge N appears on the wb_* outputs after edge N when the block was EMPTY or popped at N.
REQ-017 At capture, lane i's wreg SHALL be forced to 0 when that lane's wd equals 0; the data is still stored.
REQ-018 wb_wreg SHALL read all zeros whenever out_valid is 0; wb_wd and wb_wdata SHALL read zero when EMPTY.
REQ-019 flush at an edge SHALL force EMPTY, discard both entries, and discard any beat offered at that edge, even if in_valid && in_ready; flush takes priority over push and pop.
REQ-020 wb_* outputs SHALL hold stable while out_valid && !out_ready.

Reset
REQ-021 While rst is 0, state SHALL be EMPTY, in_ready 0, out_valid 0, and all wb_* outputs 0, independent of clk.
REQ-022 in_ready SHALL rise at the first posedge after rst deasserts; a transfer in progress when rst asserts is lost.

Configuration
REQ-023 Macro PIPE_WB_SKID_EN SHALL be defined to enable a second (skid) entry with registered in_ready as above.
REQ-024 Without PIPE_WB_SKID_EN the block SHALL hold one entry, use states EMPTY/ONE only, and drive in_ready combinationally as !out_valid || out_ready; all other requirements SHALL still hold.

Structure
REQ-025 The occupancy state encoding and the zero-register address constant SHALL live in the shared defines package; the widths SHALL come from the module parameters.
REQ-026 The per-lane zero-register write suppression SHALL be a sub-module named wb_lane_mask, instantiated LANES times.

Verification
REQ-027 After reset, push wd=3, wreg=1, wdata=0xDEADBEEF with out_ready=1 -> next cycle out_valid=1, wb_wd=3, wb_wreg=1, wb_wdata=0xDEADBEEF.
REQ-028 Push wd=0, wreg=1, wdata=0x5 -> delivered with wb_wreg=0 and wb_wdata=0x5.
REQ-029 With SKID_EN and out_ready=0, push A=0x11 then B=0x22 -> in_ready drops to 0 after B; when out_ready=1, A then B are delivered on consecutive cycles.
REQ-030 With state TWO, assert flush together with in_valid=1 -> next cycle out_valid=0, wb_wreg=0, in_ready=1, and the offered beat is never delivered.
REQ-031 With LANES=2, push lane0 {wd=1, 0xA} and lane1 {wd=2, 0xB} -> both lanes appear on the same cycle.
REQ-032 Assert rst low mid-stream, asynchronously to clk -> all outputs are 0 immediately; after release, in_ready returns to 1 after one edge.

Source files
------------

// File: rtl/pipe_wb_reg_pkg.sv
// Shared definitions for the write-back pipeline register: occupancy states
// and the hard-wired zero register address.
package pipe_wb_reg_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } occ_e;

   localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/pipe_wb_reg_lane_mask.sv
// Per-lane write-enable mask: writes aimed at the zero register are dropped,
// while the data itself is still carried through.
module wb_lane_mask
   import pipe_wb_reg_pkg::*;
#(
   parameter int unsigned ADDR_W = 5
) (
   input  logic [ADDR_W-1:0] wd,
   input  logic              wreg,
   output logic              wreg_c
);

   assign wreg_c = wreg & (wd != ADDR_W'(ZERO_REG));

endmodule

// File: rtl/pipe_wb_reg.sv
// Write-back pipeline register with valid/ready handshake and synchronous flush.
// Define PIPE_WB_SKID_EN for a two-entry (skid) build with registered in_ready.
module pipe_wb_reg
   import pipe_wb_reg_pkg::*;
#(
   parameter int unsigned LANES  = 1,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [LANES*ADDR_W-1:0]   in_wd,
   input  logic [LANES-1:0]          in_wreg,
   input  logic [LANES*DATA_W-1:0]   in_wdata,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [LANES*ADDR_W-1:0]   wb_wd,
   output logic [LANES-1:0]          wb_wreg,
   output logic [LANES*DATA_W-1:0]   wb_wdata
);

   localparam int unsigned WD_W    = LANES * ADDR_W;
   localparam int unsigned WDATA_W = LANES * DATA_W;

   occ_e               state_q, state_d;
   logic               rdy_q, rdy_d, val_d;
   logic               push_c, pop_c;
   logic [LANES-1:0]   cap_wreg_c;
   logic [WD_W-1:0]    hd_wd_d;
   logic [LANES-1:0]   hd_wreg_d;
   logic [WDATA_W-1:0] hd_wdata_d;
`ifdef PIPE_WB_SKID_EN
   logic [WD_W-1:0]    sk_wd_q, sk_wd_d;
   logic [LANES-1:0]   sk_wreg_q, sk_wreg_d;
   logic [WDATA_W-1:0] sk_wdata_q, sk_wdata_d;
`endif

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      wb_lane_mask #(.ADDR_W(ADDR_W)) u_mask (
         .wd     (in_wd[i*ADDR_W +: ADDR_W]),
         .wreg   (in_wreg[i]),
         .wreg_c (cap_wreg_c[i])
      );
   end

   // Flush outranks both handshakes.
   assign push_c = in_valid & in_ready & ~flush;
   assign pop_c  = out_valid & out_ready & ~flush;
   assign val_d  = (state_d != EMPTY);

`ifdef PIPE_WB_SKID_EN
   assign rdy_d    = (state_d != TWO);
   assign in_ready = rdy_q;
`else
   // rdy_q only marks that the first edge after reset has passed.
   assign rdy_d    = 1'b1;
   assign in_ready = rdy_q & (~out_valid | out_ready);
`endif

   // Next occupancy state and next contents of the head/skid entries.
   always_comb begin
      state_d    = state_q;
      hd_wd_d    = wb_wd;
      hd_wreg_d  = wb_wreg;
      hd_wdata_d = wb_wdata;
`ifdef PIPE_WB_SKID_EN
      sk_wd_d    = sk_wd_q;
      sk_wreg_d  = sk_wreg_q;
      sk_wdata_d = sk_wdata_q;
`endif
      if (flush) begin
         state_d    = EMPTY;
         hd_wd_d    = '0;
         hd_wreg_d  = '0;
         hd_wdata_d = '0;
      end else begin
         case (state_q)
            EMPTY: begin
               if (push_c) begin
                  state_d    = ONE;
                  hd_wd_d    = in_wd;
                  hd_wreg_d  = cap_wreg_c;
                  hd_wdata_d = in_wdata;
               end
            end
            ONE: begin
               if (push_c && pop_c) begin
                  hd_wd_d    = in_wd;
                  hd_wreg_d  = cap_wreg_c;
                  hd_wdata_d = in_wdata;
               end else if (pop_c) begin
                  state_d    = EMPTY;
                  hd_wd_d    = '0;
                  hd_wreg_d  = '0;
                  hd_wdata_d = '0;
`ifdef PIPE_WB_SKID_EN
               end else if (push_c) begin
                  state_d    = TWO;
                  sk_wd_d    = in_wd;
                  sk_wreg_d  = cap_wreg_c;
                  sk_wdata_d = in_wdata;
`endif
               end
            end
`ifdef PIPE_WB_SKID_EN
            TWO: begin
               if (pop_c) begin
                  state_d    = ONE;
                  hd_wd_d    = sk_wd_q;
                  hd_wreg_d  = sk_wreg_q;
                  hd_wdata_d = sk_wdata_q;
               end
            end
`endif
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= EMPTY;
         out_valid <= 1'b0;
         rdy_q     <= 1'b0;
         wb_wd     <= '0;
         wb_wreg   <= '0;
         wb_wdata  <= '0;
`ifdef PIPE_WB_SKID_EN
         sk_wd_q    <= '0;
         sk_wreg_q  <= '0;
         sk_wdata_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
         out_valid <= val_d;
         rdy_q     <= rdy_d;
         wb_wd     <= hd_wd_d;
         wb_wreg   <= hd_wreg_d;
         wb_wdata  <= hd_wdata_d;
`ifdef PIPE_WB_SKID_EN
         sk_wd_q    <= sk_wd_d;
         sk_wreg_q  <= sk_wreg_d;
         sk_wdata_q <= sk_wdata_d;
`endif
      end
   end

endmodule

// File: tb/tb_pipe_wb_reg.sv
// Bench for pipe_wb_reg (two lanes): queue model checked every cycle plus
// directed vectors with literal expectations; honours PIPE_WB_SKID_EN.
module tb_pipe_wb_reg;

   localparam int unsigned L  = 2;
   localparam int unsigned AW = 5;
   localparam int unsigned DW = 32;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            flush = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [L*AW-1:0] in_wd = '0;
   logic [L-1:0]    in_wreg = '0;
   logic [L*DW-1:0] in_wdata = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [L*AW-1:0] wb_wd;
   logic [L-1:0]    wb_wreg;
   logic [L*DW-1:0] wb_wdata;

   int errors = 0;
   int checks = 0;

   pipe_wb_reg #(.LANES(L), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_wd     (in_wd),
      .in_wreg   (in_wreg),
      .in_wdata  (in_wdata),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .wb_wd     (wb_wd),
      .wb_wreg   (wb_wreg),
      .wb_wdata  (wb_wdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [L*AW-1:0] wd;
      logic [L-1:0]    wreg;
      logic [L*DW-1:0] data;
   } beat_t;

   beat_t q[$];
   bit    live = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Capacity is two with the skid entry, otherwise one with pass-through ready.
   function automatic logic exp_ready();
`ifdef PIPE_WB_SKID_EN
      return live && (q.size() < 2);
`else
      return live && (q.size() == 0 || out_ready);
`endif
   endfunction

   // Reference model: ordered queue of accepted beats.
   always @(posedge clk or negedge rst) begin : model
      logic  acc, del;
      beat_t b;
      if (!rst) begin
         q.delete();
         live = 1'b0;
      end else begin
         acc = in_valid && exp_ready();
         del = (q.size() != 0) && out_ready;
         if (flush) begin
            q.delete();
         end else begin
            if (del) void'(q.pop_front());
            if (acc) begin
               b.wd   = in_wd;
               b.data = in_wdata;
               for (int i = 0; i < L; i++)
                  b.wreg[i] = in_wreg[i] && (in_wd[i*AW +: AW] != '0);
               q.push_back(b);
            end
         end
         live = 1'b1;
      end
   end

   always @(negedge clk) begin : cmp
      beat_t e;
      if (q.size() != 0) e = q[0];
      else e = '{default: '0};
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      chk("in_ready", 64'(in_ready), 64'(exp_ready()));
      chk("wb_wd", 64'(wb_wd), 64'(e.wd));
      chk("wb_wreg", 64'(wb_wreg), 64'(e.wreg));
      chk("wb_wdata", 64'(wb_wdata), 64'(e.data));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [AW-1:0] wd0, input logic [AW-1:0] wd1, input logic [1:0] wr,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1);
      in_valid = 1'b1;
      in_wd    = {wd1, wd0};
      in_wreg  = wr;
      in_wdata = {d1, d0};
   endtask

   initial begin
      // Reset held
      repeat (3) step();
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_wb_wreg", 64'(wb_wreg), 64'd0);
      @(negedge clk); #2;
      rst = 1'b1;
      #1 chk("pre_edge_in_ready", 64'(in_ready), 64'd0);
      step();
      chk("first_edge_in_ready", 64'(in_ready), 64'd1);

      // Single beat, one-cycle latency
      out_ready = 1'b1;
      offer(5'd3, 5'd0, 2'b01, 32'hDEADBEEF, 32'h0);
      step();
      in_valid = 1'b0;
      chk("beat_valid", 64'(out_valid), 64'd1);
      chk("beat_wd0", 64'(wb_wd[AW-1:0]), 64'd3);
      chk("beat_wreg", 64'(wb_wreg), 64'b01);
      chk("beat_wdata0", 64'(wb_wdata[DW-1:0]), 64'hDEADBEEF);
      step();
      chk("beat_drained", 64'(out_valid), 64'd0);
      chk("empty_wdata", 64'(wb_wdata), 64'd0);

      // Zero-register suppression on lane 0 only
      offer(5'd0, 5'd7, 2'b11, 32'h5, 32'h77);
      step();
      in_valid = 1'b0;
      chk("zero_wreg", 64'(wb_wreg), 64'b10);
      chk("zero_wdata0", 64'(wb_wdata[DW-1:0]), 64'h5);
      step();

      // Both lanes together
      offer(5'd1, 5'd2, 2'b11, 32'hA, 32'hB);
      step();
      in_valid = 1'b0;
      chk("lanes_wd", 64'(wb_wd), 64'({5'd2, 5'd1}));
      chk("lanes_wdata", 64'(wb_wdata), 64'h0000000B_0000000A);
      chk("lanes_wreg", 64'(wb_wreg), 64'b11);
      step();

      // Back-pressure: A then B
      out_ready = 1'b0;
      offer(5'd4, 5'd0, 2'b01, 32'h11, 32'h0);
      step();
      offer(5'd4, 5'd0, 2'b01, 32'h22, 32'h0);
      step();
      in_valid = 1'b0;
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_head", 64'(wb_wdata[DW-1:0]), 64'h11);
      step();
      chk("bp_hold", 64'(wb_wdata[DW-1:0]), 64'h11);
      out_ready = 1'b1;
      step();
`ifdef PIPE_WB_SKID_EN
      chk("bp_second", 64'(wb_wdata[DW-1:0]), 64'h22);
      chk("bp_second_valid", 64'(out_valid), 64'd1);
      step();
`endif
      chk("bp_done", 64'(out_valid), 64'd0);

      // Flush while full, with a beat offered at the same edge
      out_ready = 1'b0;
      offer(5'd5, 5'd0, 2'b01, 32'h33, 32'h0);
      step();
      offer(5'd6, 5'd0, 2'b01, 32'h44, 32'h0);
      step();
      flush = 1'b1;
      offer(5'd7, 5'd0, 2'b01, 32'h55, 32'h0);
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      chk("flush_valid", 64'(out_valid), 64'd0);
      chk("flush_wreg", 64'(wb_wreg), 64'd0);
      chk("flush_in_ready", 64'(in_ready), 64'd1);
      out_ready = 1'b1;
      step();
      chk("flush_discard", 64'(out_valid), 64'd0);

      // Mixed traffic
      for (int n = 0; n < 80; n++) begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 15) == 0);
         in_wd     = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
         in_wreg   = 2'($urandom_range(0, 3));
         in_wdata  = {$urandom(), $urandom()};
         step();
      end
      in_valid = 1'b0;
      flush    = 1'b0;

      // Asynchronous reset mid-stream
      out_ready = 1'b0;
      offer(5'd9, 5'd10, 2'b11, 32'h66, 32'h67);
      step();
      in_valid = 1'b0;
      step();
      #2 rst = 1'b0;
      #1;
      chk("arst_valid", 64'(out_valid), 64'd0);
      chk("arst_in_ready", 64'(in_ready), 64'd0);
      chk("arst_wd", 64'(wb_wd), 64'd0);
      chk("arst_wreg", 64'(wb_wreg), 64'd0);
      chk("arst_wdata", 64'(wb_wdata), 64'd0);
      @(negedge clk); #2;
      rst = 1'b1;
      #1 chk("arst_rel_ready", 64'(in_ready), 64'd0);
      step();
      chk("arst_ready_back", 64'(in_ready), 64'd1);
      out_ready = 1'b1;
      offer(5'd12, 5'd0, 2'b01, 32'h99, 32'h0);
      step();
      in_valid = 1'b0;
      chk("post_rst_data", 64'(wb_wdata[DW-1:0]), 64'h99);
      repeat (3) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
